mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage sitting directly downstream of the ALU. Captures the ALU result together with the store data and writeback controls, and performs at most one data-memory load or store through a request/acknowledge handshake. Presents a single-cycle writeback record to the register-file write port. ALU-only instructions pass through in one cycle; memory instructions stall the upstream stage until the memory acknowledges or times out.

## Interface
- DATA_W, 32: data and address width; matches ALU operand width.
- REG_W, 5: register-index width.
- TIMEOUT, 255: maximum cycles waited for `dmem_ack` before abandoning an access.

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  upstream record valid.
- ex_ready  out  1  stage can accept a record this cycle.
- ex_alu_result  in  DATA_W  ALU output: memory address for loads and stores, writeback data otherwise.
- ex_store_data  in  DATA_W  store data.
- ex_mem_op  in  2  MEM_NONE=0, MEM_LOAD=1, MEM_STORE=2; 3 is treated as MEM_NONE.
- ex_wb_en  in  1  instruction writes a register.
- ex_rd  in  REG_W  destination register.
- dmem_req  out  1  memory request, held until acknowledged.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DATA_W  word address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- dmem_rdata  in  DATA_W  load data.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_en  out  1  register write enable; qualified by `wb_valid`.
- wb_rd  out  REG_W  destination register.
- wb_data  out  DATA_W  writeback value.
- mem_err  out  1  sticky error flag; cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS, RETIRE.
- `ex_ready` = (state != ACCESS). A transfer occurs when `ex_valid` and `ex_ready` are both high.
- On a transfer, all `ex_*` inputs are latched.
  - MEM_NONE goes to RETIRE, with `wb_data` = `ex_alu_result`.
  - LOAD or STORE with `ex_alu_result[1:0]` != 0 is misaligned: no access is made, `mem_err` is set, and the FSM goes to RETIRE with `wb_en` forced to 0.
  - An aligned LOAD or STORE goes to ACCESS.
- ACCESS:
  - `dmem_req` = 1, with `dmem_we`, `dmem_addr` and `dmem_wdata` held stable.
  - On `dmem_ack`, the load captures `dmem_rdata` into `wb_data`; a store leaves `wb_en` forced to 0. The FSM then goes to RETIRE.
  - The wait counter increments each cycle without an ack. When it reaches TIMEOUT, `dmem_req` drops, `mem_err` is set, `wb_en` is forced to 0, and the FSM goes to RETIRE.
  - The wait counter clears on entering ACCESS.
- RETIRE:
  - `wb_valid` = 1 for exactly this cycle.
  - If a transfer occurs in the same cycle, the next state follows the new record as from IDLE; otherwise the FSM goes to IDLE.
- A `dmem_ack` arriving outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; `ex_ready` 1; `dmem_req`, `dmem_we`, `wb_valid`, `wb_en` and `mem_err` 0; `dmem_addr`, `dmem_wdata`, `wb_rd`, `wb_data` and the counter 0.
- Reset asserted mid-access drops `dmem_req` immediately (asynchronously), and the in-flight record is discarded.
- MEM_NONE latency: accepted at edge N, `wb_valid` high during cycle N+1. Back-to-back MEM_NONE records sustain one retire per cycle.
- Memory op latency:
  - `dmem_req` rises at N+1.
  - An ack seen at edge M gives `wb_valid` during cycle M+1.
  - Minimum load latency is 2 cycles (ack in the first request cycle).
- Timeout: with no ack, `dmem_req` is high for exactly TIMEOUT cycles, then `wb_valid` follows in the next cycle.
- All outputs are registered, except `ex_ready`, which decodes state only and never depends on `ex_valid`.

## Structure
- Encodings (MEM_NONE, MEM_LOAD, MEM_STORE, state codes, LOW/HIGH) are added to the shared `constants.v` alongside the existing ALU_* opcodes.
- One natural sub-module: `mem_wait_timer`, the TIMEOUT counter with clear, enable and expired outputs.

## Test plan
- MEM_NONE, `ex_alu_result`=0x0000_0005, rd=3, wb_en=1 → next cycle `wb_valid`=1, `wb_rd`=3, `wb_data`=5, no `dmem_req`.
- LOAD at addr 0x10, ack after 3 cycles with rdata=0xDEAD_BEEF → `dmem_req` high for 3 cycles, `ex_ready`=0 throughout, then `wb_data`=0xDEAD_BEEF with `wb_en`=1.
- STORE at 0x20 with data 0x1234, immediate ack → `dmem_we`=1, `dmem_wdata`=0x1234, then `wb_valid`=1 with `wb_en`=0.
- LOAD at 0x13 (misaligned) → no `dmem_req`, `mem_err`=1, `wb_valid` pulse with `wb_en`=0.
- TIMEOUT=4, LOAD with no ack → `dmem_req` high exactly 4 cycles, then `wb_en`=0 and `mem_err`=1 until reset.
- Reset asserted during ACCESS → `dmem_req` drops without waiting for a clock edge; after reset, a MEM_NONE record retires normally in 1 cycle.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared encodings for the memory-access stage: memory-operation codes, FSM
// state codes, logic-level names and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    // Memory-operation codes carried on ex_mem_op; code 3 decodes as MEM_NONE.
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RETIRE = 2'd2
    } state_e;

    // True for the two codes that touch data memory.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

    // Word accesses need the two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_stage_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for a memory acknowledge.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (entry into the access state)
//   en         : count this cycle (waiting, no acknowledge seen)
//   expired    : this enabled cycle is the TIMEOUT-th wait cycle
// -----------------------------------------------------------------------------
module mem_wait_timer
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_r;

    // Expiry is flagged during the cycle whose increment makes the count reach
    // TIMEOUT, so the request is high for exactly TIMEOUT cycles.
    assign expired = en && (count_r == LAST_CNT);

    // Wait counter: clear has priority, saturates at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != MAX_CNT)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage downstream of the ALU. Latches one record,
// performs at most one load/store over a req/ack handshake (with timeout),
// and emits a one-cycle writeback record.
//   clk, reset            : clock, asynchronous active-high reset
//   ex_valid / ex_ready   : upstream handshake (ex_ready decodes state only)
//   ex_alu_result         : address for memory ops, writeback data otherwise
//   ex_store_data         : store data
//   ex_mem_op             : NONE / LOAD / STORE (3 treated as NONE)
//   ex_wb_en, ex_rd       : writeback control
//   dmem_req/we/addr/wdata: memory request, held until ack or timeout
//   dmem_ack, dmem_rdata  : memory completion, read data valid with ack
//   wb_valid/en/rd/data   : registered one-cycle writeback record
//   mem_err               : sticky misalign/timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [1:0]        ex_mem_op,
    input  logic              ex_wb_en,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    state_e state_r;

    logic accept_s;
    logic mem_op_s;
    logic misaligned_s;
    logic start_access_s;
    logic wait_en_s;
    logic expired_s;

    assign ex_ready = (state_r != ST_ACCESS);

    // Decode of the incoming record and the handshake.
    always_comb begin
        accept_s       = LOW;
        mem_op_s       = LOW;
        misaligned_s   = LOW;
        start_access_s = LOW;
        wait_en_s      = LOW;
        if (ex_valid && (state_r != ST_ACCESS)) begin
            accept_s = HIGH;
        end else begin
            accept_s = LOW;
        end
        mem_op_s       = is_mem_op(ex_mem_op);
        misaligned_s   = mem_op_s && is_misaligned(ex_alu_result[1:0]);
        start_access_s = accept_s && mem_op_s && !misaligned_s;
        if (state_r == ST_ACCESS) begin
            wait_en_s = !dmem_ack;
        end else begin
            wait_en_s = LOW;
        end
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_access_s),
        .en      (wait_en_s),
        .expired (expired_s)
    );

    // Stage FSM with all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            dmem_req   <= LOW;
            dmem_we    <= LOW;
            dmem_addr  <= {DATA_W{1'b0}};
            dmem_wdata <= {DATA_W{1'b0}};
            wb_valid   <= LOW;
            wb_en      <= LOW;
            wb_rd      <= {REG_W{1'b0}};
            wb_data    <= {DATA_W{1'b0}};
            mem_err    <= LOW;
        end else begin
            case (state_r)
                ST_IDLE, ST_RETIRE: begin
                    if (accept_s) begin
                        wb_rd   <= ex_rd;
                        wb_data <= ex_alu_result;
                        if (!mem_op_s) begin
                            wb_en    <= ex_wb_en;
                            wb_valid <= HIGH;
                            state_r  <= ST_RETIRE;
                        end else if (misaligned_s) begin
                            wb_en    <= LOW;
                            wb_valid <= HIGH;
                            mem_err  <= HIGH;
                            state_r  <= ST_RETIRE;
                        end else begin
                            // Stores never write a register.
                            wb_en      <= (ex_mem_op == MEM_LOAD) ? ex_wb_en : LOW;
                            wb_valid   <= LOW;
                            dmem_req   <= HIGH;
                            dmem_we    <= (ex_mem_op == MEM_STORE);
                            dmem_addr  <= ex_alu_result;
                            dmem_wdata <= ex_store_data;
                            state_r    <= ST_ACCESS;
                        end
                    end else begin
                        wb_valid <= LOW;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // An ack in the final wait cycle still completes the access.
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            wb_data <= dmem_rdata;
                        end else begin
                            wb_data <= wb_data;
                        end
                        dmem_req <= LOW;
                        dmem_we  <= LOW;
                        wb_valid <= HIGH;
                        state_r  <= ST_RETIRE;
                    end else if (expired_s) begin
                        dmem_req <= LOW;
                        dmem_we  <= LOW;
                        wb_en    <= LOW;
                        wb_valid <= HIGH;
                        mem_err  <= HIGH;
                        state_r  <= ST_RETIRE;
                    end else begin
                        wb_valid <= LOW;
                        state_r  <= ST_ACCESS;
                    end
                end
                default: begin
                    dmem_req <= LOW;
                    wb_valid <= LOW;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage with TIMEOUT=4. Inputs change 1 ns after
// a rising edge and outputs are compared at that same point.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        ex_mem_op;
    logic              ex_wb_en;
    logic [REG_W-1:0]  ex_rd;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid;
    logic              wb_en;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;

    int n_checks;
    int n_fail;
    int req_cycles;

    mem_access_stage #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_op     (ex_mem_op),
        .ex_wb_en      (ex_wb_en),
        .ex_rd         (ex_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] alu,
                         input logic [31:0] sd, input logic we, input logic [4:0] rd);
        ex_valid      = v;
        ex_mem_op     = op;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_wb_en      = we;
        ex_rd         = rd;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        req_cycles = 0;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);

        // Reset state
        tick();
        check("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_mem_err",  {31'b0, mem_err},  32'd0);
        check("rst_wb_data",  wb_data,           32'd0);
        check("rst_dmem_addr", dmem_addr,        32'd0);
        reset = 1'b0;
        tick();

        // MEM_NONE, result 5 to r3
        drive(1'b1, 2'd0, 32'h0000_0005, 32'h0, 1'b1, 5'd3);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("none_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("none_wb_rd",    {27'b0, wb_rd},    32'd3);
        check("none_wb_data",  wb_data,           32'd5);
        check("none_wb_en",    {31'b0, wb_en},    32'd1);
        check("none_no_req",   {31'b0, dmem_req}, 32'd0);
        tick();
        check("none_pulse_end", {31'b0, wb_valid}, 32'd0);

        // Back-to-back MEM_NONE (op code 3 also treated as none)
        drive(1'b1, 2'd0, 32'h0000_0007, 32'h0, 1'b1, 5'd4);
        tick();
        check("b2b1_wb_data", wb_data, 32'd7);
        drive(1'b1, 2'd3, 32'h0000_0009, 32'h0, 1'b1, 5'd6);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("b2b2_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("b2b2_wb_data",  wb_data,           32'd9);
        check("b2b2_wb_rd",    {27'b0, wb_rd},    32'd6);
        check("b2b2_no_req",   {31'b0, dmem_req}, 32'd0);
        tick();

        // LOAD 0x10, ack in third request cycle
        drive(1'b1, 2'd1, 32'h0000_0010, 32'h0, 1'b1, 5'd5);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("ld_addr", dmem_addr,          32'h10);
        check("ld_we",   {31'b0, dmem_we},   32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ld_req",      {31'b0, dmem_req}, 32'd1);
            check("ld_ex_ready", {31'b0, ex_ready}, 32'd0);
            check("ld_no_wb",    {31'b0, wb_valid}, 32'd0);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("ld_wb_data",  wb_data,           32'hDEAD_BEEF);
        check("ld_wb_en",    {31'b0, wb_en},    32'd1);
        check("ld_wb_rd",    {27'b0, wb_rd},    32'd5);
        check("ld_req_drop", {31'b0, dmem_req}, 32'd0);
        check("ld_ready",    {31'b0, ex_ready}, 32'd1);
        tick();

        // STORE 0x20 data 0x1234, immediate ack
        drive(1'b1, 2'd2, 32'h0000_0020, 32'h0000_1234, 1'b1, 5'd7);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("st_req",   {31'b0, dmem_req}, 32'd1);
        check("st_we",    {31'b0, dmem_we},  32'd1);
        check("st_addr",  dmem_addr,         32'h20);
        check("st_wdata", dmem_wdata,        32'h1234);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("st_wb_en",    {31'b0, wb_en},    32'd0);
        check("st_req_drop", {31'b0, dmem_req}, 32'd0);

        // Stray ack while idle is ignored
        dmem_ack = 1'b1;
        tick();
        tick();
        dmem_ack = 1'b0;
        check("stray_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("stray_req",      {31'b0, dmem_req}, 32'd0);
        check("pre_err_clear",  {31'b0, mem_err},  32'd0);

        // Misaligned LOAD 0x13
        drive(1'b1, 2'd1, 32'h0000_0013, 32'h0, 1'b1, 5'd8);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("mis_no_req",   {31'b0, dmem_req}, 32'd0);
        check("mis_mem_err",  {31'b0, mem_err},  32'd1);
        check("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("mis_wb_en",    {31'b0, wb_en},    32'd0);
        tick();

        // Clear sticky error with reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", {31'b0, mem_err}, 32'd0);

        // LOAD with no ack: request high for exactly TIMEOUT cycles
        drive(1'b1, 2'd1, 32'h0000_0040, 32'h0, 1'b1, 5'd9);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (dmem_req) begin
                req_cycles++;
                tick();
            end
        end
        check("to_req_cycles", req_cycles,         TIMEOUT);
        check("to_wb_valid",   {31'b0, wb_valid},  32'd1);
        check("to_wb_en",      {31'b0, wb_en},     32'd0);
        check("to_mem_err",    {31'b0, mem_err},   32'd1);
        tick();
        tick();
        check("to_err_sticky", {31'b0, mem_err},   32'd1);
        check("to_idle_ready", {31'b0, ex_ready},  32'd1);

        // Reset mid-access drops the request without a clock edge
        drive(1'b1, 2'd1, 32'h0000_0080, 32'h0, 1'b1, 5'd10);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("ra_req_up", {31'b0, dmem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ra_req_async", {31'b0, dmem_req}, 32'd0);
        check("ra_ready",     {31'b0, ex_ready}, 32'd1);
        check("ra_err_clr",   {31'b0, mem_err},  32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 2'd0, 32'h0000_00AB, 32'h0, 1'b1, 5'd12);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        check("ra_none_valid", {31'b0, wb_valid}, 32'd1);
        check("ra_none_data",  wb_data,           32'hAB);
        check("ra_none_rd",    {27'b0, wb_rd},    32'd12);
        check("ra_none_noreq", {31'b0, dmem_req}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
